tdm_demux4: RTL and testbench

- Time-division demultiplexer: receives a serial stream of WIDTH-bit slots framed by a sync marker and distributes slots 0..3 onto four parallel output registers.
- Receive-side counterpart of the 4-way mux switch; sits between the shared TDM line and the four per-channel consumers.
- Outputs update atomically once per complete frame.

---
 rtl/tdm_demux4.sv | 216 +++++++++++++++++++++
 tb/tb_tdm_demux4.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
//
// Receive-side time-division demultiplexer. A shared serial line carries
// frames of four WIDTH-bit slots; the first slot of each frame is flagged by
// `sync`. The block locks onto the frame structure, collects slots 0..2 in
// shadow registers and, when slot 3 arrives, moves the whole frame to the four
// output registers on a single edge so consumers never see a partial update.
//
// Optional feature macro: TDM_DEMUX_PARITY_EN
//   When defined, each beat carries an even-parity bit (din_par). A frame
//   containing any bad beat is dropped at slot 3 and par_err pulses instead of
//   frame_valid. When undefined, din_par/par_err do not exist and every
//   complete frame is delivered.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   din          in   slot data (WIDTH)
//   din_valid    in   beat qualifier; din/sync/din_par sampled only when high
//   sync         in   current beat is slot 0 of a frame
//   din_par      in   even parity over din (parity build only)
//   out0..out3   out  channel data from slots 0..3 of the last good frame
//   frame_valid  out  one-cycle pulse: out0..out3 just updated
//   slot         out  index of the next slot expected
//   locked       out  high while receiving framed data
//   sync_err     out  one-cycle pulse: framing error detected
//   par_err      out  one-cycle pulse: frame dropped for parity (parity build)
// ---------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic             din_par,
    output logic             par_err,
`endif
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    localparam logic [0:0] StateHunt = 1'b0;
    localparam logic [0:0] StateRecv = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow0_q, shadow0_d;
    logic [WIDTH-1:0] shadow1_q, shadow1_d;
    logic [WIDTH-1:0] shadow2_q, shadow2_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [WIDTH-1:0] out3_q, out3_d;
    logic             frameValid_q, frameValid_d;
    logic             syncErr_q, syncErr_d;
    logic             frameDone;

`ifdef TDM_DEMUX_PARITY_EN
    logic             bad_q, bad_d;
    logic             parErr_q, parErr_d;
    logic             beatBad;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign beatBad = ^{din, din_par};
`endif

    // Frame tracking. Nothing moves unless a beat is accepted, so gaps anywhere
    // in a frame simply stall the slot counter. The slot-3 beat bypasses the
    // shadow registers and lands directly in out3 together with the shadows,
    // which is what makes the output update atomic.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shadow0_d    = shadow0_q;
        shadow1_d    = shadow1_q;
        shadow2_d    = shadow2_q;
        syncErr_d    = 1'b0;
        frameDone    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        bad_d        = bad_q;
`endif
        if (din_valid) begin
            if (state_q == StateHunt) begin
                if (sync) begin
                    shadow0_d = din;
                    slot_d    = 2'd1;
                    state_d   = StateRecv;
`ifdef TDM_DEMUX_PARITY_EN
                    bad_d     = beatBad;
`endif
                end
            end else begin
                if (sync) begin
                    // A sync mid-frame abandons the partial frame and restarts
                    // on this beat rather than dropping lock.
                    if (slot_q != 2'd0) begin
                        syncErr_d = 1'b1;
                    end
                    shadow0_d = din;
                    slot_d    = 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
                    bad_d     = beatBad;
`endif
                end else if (slot_q == 2'd0) begin
                    // Expected a sync and did not get one: framing is lost.
                    syncErr_d = 1'b1;
                    state_d   = StateHunt;
                    slot_d    = 2'd0;
                end else begin
                    slot_d = slot_q + 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
                    if (beatBad) begin
                        bad_d = 1'b1;
                    end
`endif
                    case (slot_q)
                        2'd1:    shadow1_d = din;
                        2'd2:    shadow2_d = din;
                        default: frameDone = 1'b1;
                    endcase
                end
            end
        end
    end

    // Output stage: either the whole frame is published or nothing changes.
    always_comb begin
        out0_d       = out0_q;
        out1_d       = out1_q;
        out2_d       = out2_q;
        out3_d       = out3_q;
        frameValid_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        parErr_d     = 1'b0;
        if (frameDone) begin
            if (bad_q || beatBad) begin
                parErr_d = 1'b1;
            end else begin
                out0_d       = shadow0_q;
                out1_d       = shadow1_q;
                out2_d       = shadow2_q;
                out3_d       = din;
                frameValid_d = 1'b1;
            end
        end
`else
        if (frameDone) begin
            out0_d       = shadow0_q;
            out1_d       = shadow1_q;
            out2_d       = shadow2_q;
            out3_d       = din;
            frameValid_d = 1'b1;
        end
`endif
    end

    // State registers; reset wins over any beat on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StateHunt;
            slot_q       <= 2'd0;
            shadow0_q    <= '0;
            shadow1_q    <= '0;
            shadow2_q    <= '0;
            out0_q       <= '0;
            out1_q       <= '0;
            out2_q       <= '0;
            out3_q       <= '0;
            frameValid_q <= 1'b0;
            syncErr_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            bad_q        <= 1'b0;
            parErr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow0_q    <= shadow0_d;
            shadow1_q    <= shadow1_d;
            shadow2_q    <= shadow2_d;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
            out2_q       <= out2_d;
            out3_q       <= out3_d;
            frameValid_q <= frameValid_d;
            syncErr_q    <= syncErr_d;
`ifdef TDM_DEMUX_PARITY_EN
            bad_q        <= bad_d;
            parErr_q     <= parErr_d;
`endif
        end
    end

    assign out0        = out0_q;
    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign frame_valid = frameValid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == StateRecv);
    assign sync_err    = syncErr_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign par_err     = parErr_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux4
//
// Testbench for tdm_demux4 (WIDTH=4). Frames that should be delivered are
// pushed to a scoreboard queue as their last beat is driven; a monitor pops
// and compares whenever the DUT pulses frame_valid. Each scenario task checks
// the control outputs (slot, locked, sync_err, frame_valid) inline.
// Build with TDM_DEMUX_PARITY_EN defined to also exercise the parity path.
// ---------------------------------------------------------------------------
module tb_tdm_demux4;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic [W-1:0]   din;
    logic           din_valid;
    logic           sync;
    logic [W-1:0]   out0, out1, out2, out3;
    logic           frame_valid;
    logic [1:0]     slot;
    logic           locked;
    logic           sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic           din_par;
    logic           par_err;
`endif

    int assertCount = 0;
    int failCount   = 0;

    logic [4*W-1:0] expectQ[$];

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
`ifdef TDM_DEMUX_PARITY_EN
        .din_par     (din_par),
        .par_err     (par_err),
`endif
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every frame_valid pulse must match the oldest
    // expected frame, and an unexpected pulse is itself a failure.
    always @(negedge clk) begin
        logic [4*W-1:0] exp;
        if (rst === 1'b0 && frame_valid === 1'b1) begin
            assertCount++;
            if (expectQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL frame_unexpected got=%h_%h_%h_%h expected no frame", out0, out1, out2, out3);
            end else begin
                exp = expectQ.pop_front();
                if ({out0, out1, out2, out3} !== exp) begin
                    failCount++;
                    $display("[TB] FAIL frame_data got=%h expected=%h", {out0, out1, out2, out3}, exp);
                end
            end
        end
    end

    // Drive one accepted beat; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic [W-1:0] data, input logic syncBit);
        din       = data;
        sync      = syncBit;
`ifdef TDM_DEMUX_PARITY_EN
        din_par   = ^data;
`endif
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        assertCount++;
        if ({out0, out1, out2, out3} !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL reset_outs got=%h expected=0000", {out0, out1, out2, out3});
        end
        assertCount++;
        if (frame_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_frame_valid got=%b expected=0", frame_valid);
        end
        assertCount++;
        if (locked !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_locked got=%b expected=0", locked);
        end
        assertCount++;
        if (slot !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL reset_slot got=%0d expected=0", slot);
        end
        assertCount++;
        if (sync_err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_sync_err got=%b expected=0", sync_err);
        end
        // Unsynchronised beats while hunting are discarded.
        applyStimulus(4'h7, 1'b0);
        assertCount++;
        if (locked !== 1'b0 || slot !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL hunt_discard got locked=%b slot=%0d expected locked=0 slot=0", locked, slot);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(4'hA, 1'b1);
        assertCount++;
        if (locked !== 1'b1 || slot !== 2'd1) begin
            failCount++;
            $display("[TB] FAIL b2b_lock got locked=%b slot=%0d expected locked=1 slot=1", locked, slot);
        end
        applyStimulus(4'hB, 1'b0);
        applyStimulus(4'hC, 1'b0);
        assertCount++;
        if (frame_valid !== 1'b0 || {out0, out1, out2, out3} !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL b2b_early got fv=%b outs=%h expected fv=0 outs=0000", frame_valid, {out0, out1, out2, out3});
        end
        expectQ.push_back({4'hA, 4'hB, 4'hC, 4'hD});
        applyStimulus(4'hD, 1'b0);
        assertCount++;
        if (frame_valid !== 1'b1 || locked !== 1'b1 || slot !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL b2b_done got fv=%b locked=%b slot=%0d expected fv=1 locked=1 slot=0", frame_valid, locked, slot);
        end
        idle(1);
        assertCount++;
        if (frame_valid !== 1'b0 || {out0, out1, out2, out3} !== 16'hABCD) begin
            failCount++;
            $display("[TB] FAIL b2b_pulse_width got fv=%b outs=%h expected fv=0 outs=abcd", frame_valid, {out0, out1, out2, out3});
        end
    endtask

    task automatic test_gaps();
        logic [W-1:0] beats [4];
        beats[0] = 4'h3;
        beats[1] = 4'h5;
        beats[2] = 4'h7;
        beats[3] = 4'h9;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) expectQ.push_back({4'h3, 4'h5, 4'h7, 4'h9});
            applyStimulus(beats[i], (i == 0));
            if (i < 3) begin
                idle(2);
                assertCount++;
                if (slot !== 2'(i + 1) || frame_valid !== 1'b0 || {out0, out1, out2, out3} !== 16'hABCD) begin
                    failCount++;
                    $display("[TB] FAIL gap_hold_%0d got slot=%0d fv=%b outs=%h expected slot=%0d fv=0 outs=abcd",
                             i, slot, frame_valid, {out0, out1, out2, out3}, i + 1);
                end
            end
        end
        assertCount++;
        if (frame_valid !== 1'b1 || slot !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL gap_done got fv=%b slot=%0d expected fv=1 slot=0", frame_valid, slot);
        end
        idle(1);
    endtask

    task automatic test_resync();
        applyStimulus(4'h1, 1'b1);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h3, 1'b0);
        applyStimulus(4'h5, 1'b1);
        assertCount++;
        if (sync_err !== 1'b1 || locked !== 1'b1 || slot !== 2'd1) begin
            failCount++;
            $display("[TB] FAIL resync_err got se=%b locked=%b slot=%0d expected se=1 locked=1 slot=1", sync_err, locked, slot);
        end
        assertCount++;
        if ({out0, out1, out2, out3} !== 16'h3579) begin
            failCount++;
            $display("[TB] FAIL resync_hold got=%h expected=3579", {out0, out1, out2, out3});
        end
        applyStimulus(4'h6, 1'b0);
        assertCount++;
        if (sync_err !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL resync_pulse_width got=%b expected=0", sync_err);
        end
        applyStimulus(4'h7, 1'b0);
        expectQ.push_back({4'h5, 4'h6, 4'h7, 4'h8});
        applyStimulus(4'h8, 1'b0);
        assertCount++;
        if (frame_valid !== 1'b1 || locked !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL resync_frame got fv=%b locked=%b expected fv=1 locked=1", frame_valid, locked);
        end
        idle(1);
    endtask

    task automatic test_lost_sync();
        applyStimulus(4'h9, 1'b0);
        assertCount++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || slot !== 2'd0 || frame_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL lost_sync got se=%b locked=%b slot=%0d fv=%b expected se=1 locked=0 slot=0 fv=0",
                     sync_err, locked, slot, frame_valid);
        end
        idle(1);
        assertCount++;
        if (sync_err !== 1'b0 || {out0, out1, out2, out3} !== 16'h5678) begin
            failCount++;
            $display("[TB] FAIL lost_sync_hold got se=%b outs=%h expected se=0 outs=5678", sync_err, {out0, out1, out2, out3});
        end
    endtask

    task automatic test_reset_midframe();
        applyStimulus(4'h4, 1'b1);
        applyStimulus(4'hE, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        assertCount++;
        if ({out0, out1, out2, out3} !== 16'h0000 || locked !== 1'b0 || slot !== 2'd0 || frame_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midframe_reset got outs=%h locked=%b slot=%0d fv=%b expected outs=0000 locked=0 slot=0 fv=0",
                     {out0, out1, out2, out3}, locked, slot, frame_valid);
        end
        // Recovery: a clean frame after reset is delivered normally.
        applyStimulus(4'h1, 1'b1);
        applyStimulus(4'h2, 1'b0);
        applyStimulus(4'h4, 1'b0);
        expectQ.push_back({4'h1, 4'h2, 4'h4, 4'h8});
        applyStimulus(4'h8, 1'b0);
        assertCount++;
        if (frame_valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midframe_recover got fv=%b expected=1", frame_valid);
        end
        idle(1);
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic test_parity();
        applyStimulus(4'hC, 1'b1);
        // Beat with deliberately wrong parity.
        din       = 4'h3;
        sync      = 1'b0;
        din_par   = ~(^din);
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        applyStimulus(4'h5, 1'b0);
        applyStimulus(4'h6, 1'b0);
        assertCount++;
        if (par_err !== 1'b1 || frame_valid !== 1'b0 || {out0, out1, out2, out3} !== 16'h1248) begin
            failCount++;
            $display("[TB] FAIL parity_drop got pe=%b fv=%b outs=%h expected pe=1 fv=0 outs=1248",
                     par_err, frame_valid, {out0, out1, out2, out3});
        end
        // Bad flag must clear at the next slot-0 capture.
        applyStimulus(4'hF, 1'b1);
        applyStimulus(4'hE, 1'b0);
        applyStimulus(4'hD, 1'b0);
        expectQ.push_back({4'hF, 4'hE, 4'hD, 4'hC});
        applyStimulus(4'hC, 1'b0);
        assertCount++;
        if (par_err !== 1'b0 || frame_valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL parity_clear got pe=%b fv=%b expected pe=0 fv=1", par_err, frame_valid);
        end
        idle(1);
    endtask
`endif

    task automatic test_drain();
        idle(2);
        assertCount++;
        if (expectQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drain got %0d pending frames expected 0", expectQ.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        sync      = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        din_par   = 1'b0;
`endif
        test_reset();
        test_back_to_back();
        test_gaps();
        test_resync();
        test_lost_sync();
        test_reset_midframe();
`ifdef TDM_DEMUX_PARITY_EN
        test_parity();
`endif
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
